// File: rtl/four_fa_pkg.sv
// four_fa_pkg: shared width constant for the 4-bit adder; bit index 0 is the LSB.
package four_fa_pkg;
  localparam int WIDTH = 4;
  localparam int LSB = 0;
endpackage

// File: rtl/four_fa_if.sv
// four_fa_if: operand/result bundle for the 4-bit adder, LSB at index 0.
interface four_fa_if;
  import four_fa_pkg::*;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] s;
  logic c4;
  modport master(output a, b, input s, c4);
  modport slave(input a, b, output s, c4);
endinterface

// File: rtl/full_adder.sv
// full_adder: single-bit full adder stage of the ripple chain.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  always_comb begin
    s  = a ^ b ^ ci;
    co = (a & b) | (ci & (a ^ b));
  end
endmodule

// File: rtl/four_fa.sv
// four_fa: 4-bit ripple-carry adder whose sum and carry-out are captured in flops.
module four_fa
  import four_fa_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic A0,
  input  logic A1,
  input  logic A2,
  input  logic A3,
  input  logic B0,
  input  logic B1,
  input  logic B2,
  input  logic B3,
  output logic S0,
  output logic S1,
  output logic S2,
  output logic S3,
  output logic C4
);
  logic [WIDTH-1:0] a, b, s;
  logic [WIDTH:0] c;
  logic [WIDTH:0] res_d, res_q;
  assign a = {A3, A2, A1, A0};
  assign b = {B3, B2, B1, B0};
  assign c[LSB] = 1'b0;
  for (genvar i = 0; i < WIDTH; i++) begin : g_stage
    full_adder u_fa (
      .a (a[i]),
      .b (b[i]),
      .ci(c[i]),
      .s (s[i]),
      .co(c[i+1])
    );
  end
  always_comb res_d = {c[WIDTH], s};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) res_q <= '0;
    else res_q <= res_d;
  assign {C4, S3, S2, S1, S0} = res_q;
endmodule

// File: tb/tb_four_fa.sv
// tb_four_fa: randomized and directed check of four_fa against an arithmetic reference.
module tb_four_fa;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_checks = 0;
  int n_fail = 0;
  logic [4:0] pend;
  four_fa_if bus ();
  four_fa dut (
    .clk  (clk),
    .rst_n(rst_n),
    .A0(bus.a[0]), .A1(bus.a[1]), .A2(bus.a[2]), .A3(bus.a[3]),
    .B0(bus.b[0]), .B1(bus.b[1]), .B2(bus.b[2]), .B3(bus.b[3]),
    .S0(bus.s[0]), .S1(bus.s[1]), .S2(bus.s[2]), .S3(bus.s[3]),
    .C4(bus.c4)
  );
  always #5 clk = ~clk;
  function automatic logic [4:0] got();
    return {bus.c4, bus.s};
  endfunction
  task automatic check(input string tag, input logic [4:0] act, input logic [4:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (c4=%b s=%b) expected %0d", tag, act, act[4], act[3:0], exp);
    end
  endtask
  // Check the result of the previous pair, apply a new pair, then confirm the output holds until the edge.
  task automatic step(input string tag, input logic [3:0] a, input logic [3:0] b);
    @(negedge clk);
    check(tag, got(), pend);
    bus.a = a;
    bus.b = b;
    #1 check({tag, "_hold"}, got(), pend);
    pend = {1'b0, a} + {1'b0, b};
  endtask
  initial begin
    bus.a = 4'($urandom);
    bus.b = 4'($urandom);
    pend = '0;
    repeat (3) begin
      @(negedge clk);
      check("reset", got(), 5'd0);
      bus.a = 4'($urandom);
      bus.b = 4'($urandom);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bus.a = 4'd0;
    bus.b = 4'd0;
    pend = 5'd0;
    step("15+9", 4'd15, 4'd9);
    step("5+10", 4'd5, 4'd10);
    step("8+12", 4'd8, 4'd12);
    step("1+14", 4'd1, 4'd14);
    step("15+15", 4'd15, 4'd15);
    step("0+0", 4'd0, 4'd0);
    step("last_dir", 4'd0, 4'd0);
    for (int k = 0; k < 200; k++) step("rand", 4'($urandom), 4'($urandom));
    step("pre", 4'd15, 4'd15);
    step("pre2", 4'd15, 4'd15);
    @(posedge clk);
    #2 check("before_rst", got(), 5'd30);
    rst_n = 1'b0;
    #1 check("async_clr", got(), 5'd0);
    @(posedge clk);
    #1 check("rst_held", got(), 5'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.a = 4'd3;
    bus.b = 4'd4;
    pend = 5'd7;
    for (int k = 0; k < 20; k++) step("post_rst", 4'($urandom), 4'($urandom));
    @(negedge clk);
    check("final", got(), pend);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
